btn_rst_cond: RTL and testbench



---
 rtl/btn_rst_cond.sv | 152 +++++++++++++++
 tb/tb_btn_rst_cond.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_rst_cond.sv
// ============================================================================
// Module   : btn_rst_cond
// Purpose  : Turns a raw bouncing reset button into a clean, stretched,
//            synchronous reset level with a power-on hold interval.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_rst_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int POR_CYCLES      = 16,
    parameter int MIN_RST_CYCLES  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic cpu_rst,
    output logic rst_release,
    output logic btn_level
);

    localparam int c_deb_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_por_w  = $clog2(POR_CYCLES + 1);
    localparam int c_hold_w = $clog2(MIN_RST_CYCLES + 1);

    localparam logic [c_deb_w-1:0]  c_deb_max  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_por_w-1:0]  c_por_max  = c_por_w'(POR_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MIN_RST_CYCLES - 1);

    localparam logic [1:0] c_st_por     = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_hold    = 2'd2;
    localparam logic [1:0] c_st_stretch = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_sync;
    logic [c_deb_w-1:0]     r_deb_cnt;
    logic                   r_btn_level;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_por_w-1:0]     r_por_cnt;
    logic [c_por_w-1:0]     w_por_cnt_nxt;
    logic [c_hold_w-1:0]    r_hold_cnt;
    logic [c_hold_w-1:0]    w_hold_cnt_nxt;
    logic [c_hold_w-1:0]    w_hold_inc;
    logic                   w_hold_met;
    logic                   r_cpu_rst;
    logic                   w_cpu_rst_nxt;
    logic                   r_rst_release;
    logic                   w_rst_release_nxt;

    // Synchronizer chain: bit 0 samples the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign w_btn_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt   <= '0;
            r_btn_level <= 1'b0;
        end else if (w_btn_sync == r_btn_level) begin
            r_deb_cnt   <= '0;
        end else if (r_deb_cnt == c_deb_max) begin
            r_deb_cnt   <= '0;
            r_btn_level <= w_btn_sync;
        end else begin
            r_deb_cnt   <= r_deb_cnt + c_deb_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_por;
            r_por_cnt     <= '0;
            r_hold_cnt    <= '0;
            r_cpu_rst     <= 1'b1;
            r_rst_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_por_cnt     <= w_por_cnt_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_cpu_rst     <= w_cpu_rst_nxt;
            r_rst_release <= w_rst_release_nxt;
        end
    end

    assign w_hold_met = (r_hold_cnt >= c_hold_max);
    assign w_hold_inc = w_hold_met ? r_hold_cnt : (r_hold_cnt + c_hold_w'(1));

    // HOLD and STRETCH share the width counter so a re-press keeps its credit.
    always_comb begin
        w_state_nxt    = r_state;
        w_por_cnt_nxt  = r_por_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            c_st_por: begin
                w_por_cnt_nxt = r_por_cnt + c_por_w'(1);
                if (r_por_cnt == c_por_max) begin
                    if (r_btn_level) begin
                        w_state_nxt    = c_st_hold;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_state_nxt    = c_st_run;
                    end
                end
            end
            c_st_run: begin
                if (r_btn_level) begin
                    w_state_nxt    = c_st_hold;
                    w_hold_cnt_nxt = '0;
                end
            end
            c_st_hold: begin
                w_hold_cnt_nxt = w_hold_inc;
                if (!r_btn_level) begin
                    w_state_nxt = w_hold_met ? c_st_run : c_st_stretch;
                end
            end
            c_st_stretch: begin
                w_hold_cnt_nxt = w_hold_inc;
                if (r_btn_level) begin
                    w_state_nxt = c_st_hold;
                end else if (w_hold_met) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: begin
                w_state_nxt = c_st_por;
            end
        endcase
    end

    always_comb begin
        w_cpu_rst_nxt     = (w_state_nxt != c_st_run);
        w_rst_release_nxt = (w_state_nxt == c_st_run) && (r_state != c_st_run);
    end

    assign cpu_rst     = r_cpu_rst;
    assign rst_release = r_rst_release;
    assign btn_level   = r_btn_level;

endmodule

`default_nettype wire

// File: tb/tb_btn_rst_cond.sv
// ============================================================================
// Module   : tb_btn_rst_cond
// Purpose  : Scoreboard bench for btn_rst_cond against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btn_rst_cond;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int POR  = 5;
    localparam int MINW = 8;

    typedef struct packed {
        logic cpu;
        logic rel;
        logic lvl;
    } exp_t;

    logic clk;
    logic rst;
    logic btn_in;
    logic cpu_rst;
    logic rst_release;
    logic btn_level;

    exp_t exp_q[$];
    int   errors;
    int   checks;
    int   cyc;

    // Model state: sync delay line, debounce run length, reset episode tracking.
    bit   m_sq[$];
    bit   m_level;
    int   m_run;
    bit   m_cpu;
    bit   m_rel;
    bit   m_in_por;
    int   m_age;
    int   m_len;

    btn_rst_cond #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .POR_CYCLES      (POR),
        .MIN_RST_CYCLES  (MINW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .cpu_rst     (cpu_rst),
        .rst_release (rst_release),
        .btn_level   (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input bit r, input bit b);
        bit sync_old;
        bit lvl_old;
        bit cpu_old;
        if (r) begin
            m_sq.delete();
            for (int i = 0; i < SYNC; i++) m_sq.push_back(1'b0);
            m_level  = 1'b0;
            m_run    = 0;
            m_cpu    = 1'b1;
            m_rel    = 1'b0;
            m_in_por = 1'b1;
            m_age    = 0;
            m_len    = 0;
            return;
        end
        sync_old = (m_sq.size() > 0) ? m_sq[0] : 1'b0;
        lvl_old  = m_level;
        cpu_old  = m_cpu;
        if (m_sq.size() > 0) void'(m_sq.pop_front());
        m_sq.push_back(b);

        // Level flips only after DEB consecutive disagreeing samples.
        if (sync_old != lvl_old) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = sync_old;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end

        if (m_in_por) begin
            m_age++;
            if (m_age == POR) begin
                m_in_por = 1'b0;
                if (lvl_old) begin
                    m_cpu = 1'b1;
                    m_len = 1;
                end else begin
                    m_cpu = 1'b0;
                end
            end
        end else if (!cpu_old) begin
            if (lvl_old) begin
                m_cpu = 1'b1;
                m_len = 1;
            end
        end else if (!lvl_old && m_len >= MINW) begin
            m_cpu = 1'b0;
        end else begin
            m_len++;
        end
        m_rel = cpu_old && !m_cpu;
    endtask

    task automatic drive(input bit r, input bit b);
        exp_t e;
        @(posedge clk);
        #3;
        rst    = r;
        btn_in = b;
        model_edge(r, b);
        e.cpu = m_cpu;
        e.rel = m_rel;
        e.lvl = m_level;
        exp_q.push_back(e);
    endtask

    task automatic hold_btn(input bit b, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, b);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, compared 1 ns after the edge.
    initial begin
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit("cpu_rst", cpu_rst, e.cpu);
                check_bit("rst_release", rst_release, e.rel);
                check_bit("btn_level", btn_level, e.lvl);
            end
        end
    end

    initial begin
        int len;
        bit val;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        btn_in = 1'b0;

        // Power-on
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        hold_btn(1'b0, 10);

        // Glitch reject
        hold_btn(1'b1, 3);
        for (int i = 0; i < 10; i++) drive(1'b0, i[0] ? 1'b0 : 1'b1);
        hold_btn(1'b0, 10);

        // Long press
        hold_btn(1'b1, 20);
        hold_btn(1'b0, 20);

        // Short press stretched to minimum width
        hold_btn(1'b1, 5);
        hold_btn(1'b0, 20);

        // Re-press while stretching
        hold_btn(1'b1, 5);
        hold_btn(1'b0, 3);
        hold_btn(1'b1, 5);
        hold_btn(1'b0, 20);

        // Reset while holding
        hold_btn(1'b1, 10);
        drive(1'b1, 1'b1);
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 25);

        // Button held across a full power-on interval
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        hold_btn(1'b1, 15);
        hold_btn(1'b0, 25);

        // Randomized segments with bounce and occasional resets
        for (int s = 0; s < 80; s++) begin
            len = $urandom_range(1, 12);
            val = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                for (int k = 0; k < $urandom_range(1, 2); k++) drive(1'b1, val);
            end
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) drive(1'b0, ~val);
                else drive(1'b0, val);
            end
        end
        hold_btn(1'b0, 30);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
